// File: rtl/decode_stage.sv
// RV32I decode stage: drives regfile read addresses from the fetch word, decodes
// opcode class / immediate / rd, and registers everything into the ex_* stage.
// Only load-use needs a stall; all other dependencies are forwarded in execute.
module decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_instr,
    input  logic [31:0] fetch_pc,
    output logic        fetch_ready,
    output logic [4:0]  rs1_address,
    output logic [4:0]  rs2_address,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        ex_ready,
    input  logic        flush,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rd_address,
    output logic [2:0]  ex_funct3,
    output logic        ex_alt,
    output logic [3:0]  ex_opclass
);

    localparam logic [3:0] ClsOp      = 4'd0;
    localparam logic [3:0] ClsOpImm   = 4'd1;
    localparam logic [3:0] ClsLoad    = 4'd2;
    localparam logic [3:0] ClsStore   = 4'd3;
    localparam logic [3:0] ClsBranch  = 4'd4;
    localparam logic [3:0] ClsJal     = 4'd5;
    localparam logic [3:0] ClsJalr    = 4'd6;
    localparam logic [3:0] ClsLui     = 4'd7;
    localparam logic [3:0] ClsAuipc   = 4'd8;
    localparam logic [3:0] ClsNop     = 4'd9;
    localparam logic [3:0] ClsIllegal = 4'd15;

    logic [3:0]  opclass;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        alt;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        keep_rd;
    logic        hz;
    logic        advance;

    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

    logic        ex_valid_q;
    logic [31:0] ex_pc_q, ex_rs1_data_q, ex_rs2_data_q, ex_imm_q;
    logic [4:0]  ex_rd_q;
    logic [2:0]  ex_funct3_q;
    logic        ex_alt_q;
    logic [3:0]  ex_opclass_q;

    assign rs1_address = fetch_instr[19:15];
    assign rs2_address = fetch_instr[24:20];

    assign imm_i = {{20{fetch_instr[31]}}, fetch_instr[31:20]};
    assign imm_s = {{20{fetch_instr[31]}}, fetch_instr[31:25], fetch_instr[11:7]};
    assign imm_b = {{19{fetch_instr[31]}}, fetch_instr[31], fetch_instr[7],
                    fetch_instr[30:25], fetch_instr[11:8], 1'b0};
    assign imm_j = {{11{fetch_instr[31]}}, fetch_instr[31], fetch_instr[19:12],
                    fetch_instr[20], fetch_instr[30:21], 1'b0};
    assign imm_u = {fetch_instr[31:12], 12'b0};

    // Opcode decode: class, immediate format, register usage and rd retention.
    always_comb begin
        opclass  = ClsIllegal;
        imm      = '0;
        alt      = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        keep_rd  = 1'b0;
        // Full 7-bit match also rejects words whose low two bits are not 2'b11.
        case (fetch_instr[6:0])
            7'b0110011: begin
                opclass = ClsOp; alt = fetch_instr[30];
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; keep_rd = 1'b1;
            end
            7'b0010011: begin
                opclass = ClsOpImm; imm = imm_i; uses_rs1 = 1'b1; keep_rd = 1'b1;
                // instr[30] only distinguishes SRAI from SRLI; elsewhere it is imm.
                alt = (fetch_instr[14:12] == 3'b101) ? fetch_instr[30] : 1'b0;
            end
            7'b0000011: begin
                opclass = ClsLoad; imm = imm_i; uses_rs1 = 1'b1; keep_rd = 1'b1;
            end
            7'b0100011: begin
                opclass = ClsStore; imm = imm_s; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            7'b1100011: begin
                opclass = ClsBranch; imm = imm_b; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            7'b1101111: begin
                opclass = ClsJal; imm = imm_j; keep_rd = 1'b1;
            end
            7'b1100111: begin
                opclass = ClsJalr; imm = imm_i; uses_rs1 = 1'b1; keep_rd = 1'b1;
            end
            7'b0110111: begin
                opclass = ClsLui; imm = imm_u; keep_rd = 1'b1;
            end
            7'b0010111: begin
                opclass = ClsAuipc; imm = imm_u; keep_rd = 1'b1;
            end
            7'b1110011, 7'b0001111: begin
                opclass = ClsNop; imm = imm_i;
            end
            default: begin
                opclass = ClsIllegal;
            end
        endcase
    end

    assign rd = keep_rd ? fetch_instr[11:7] : 5'd0;

    assign hz = ex_valid_q && (ex_opclass_q == ClsLoad) && (ex_rd_q != 5'd0) && fetch_valid &&
                ((uses_rs1 && (rs1_address == ex_rd_q)) ||
                 (uses_rs2 && (rs2_address == ex_rd_q)));

    assign advance     = !ex_valid_q || ex_ready;
    assign fetch_ready = advance && !hz && !flush;

    // Execute-facing pipeline register: flush, bubble, capture, drain or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= RESET_PC;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_rd_q       <= '0;
            ex_funct3_q   <= '0;
            ex_alt_q      <= 1'b0;
            ex_opclass_q  <= '0;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
        end else if (advance) begin
            if (hz || !fetch_valid) begin
                ex_valid_q <= 1'b0;
            end else begin
                ex_valid_q    <= 1'b1;
                ex_pc_q       <= fetch_pc;
                ex_rs1_data_q <= rs1_data;
                ex_rs2_data_q <= rs2_data;
                ex_imm_q      <= imm;
                ex_rd_q       <= rd;
                ex_funct3_q   <= fetch_instr[14:12];
                ex_alt_q      <= alt;
                ex_opclass_q  <= opclass;
            end
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_pc         = ex_pc_q;
    assign ex_rs1_data   = ex_rs1_data_q;
    assign ex_rs2_data   = ex_rs2_data_q;
    assign ex_imm        = ex_imm_q;
    assign ex_rd_address = ex_rd_q;
    assign ex_funct3     = ex_funct3_q;
    assign ex_alt        = ex_alt_q;
    assign ex_opclass    = ex_opclass_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus a randomized run against a
// format-table reference model of the decode and the stage's handshake rules.
module tb_decode_stage;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic [4:0]  rs1_address;
    logic [4:0]  rs2_address;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        ex_ready;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd_address;
    logic [2:0]  ex_funct3;
    logic        ex_alt;
    logic [3:0]  ex_opclass;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decode_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
        .fetch_ready(fetch_ready),
        .rs1_address(rs1_address), .rs2_address(rs2_address),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_ready(ex_ready), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rd_address(ex_rd_address),
        .ex_funct3(ex_funct3), .ex_alt(ex_alt), .ex_opclass(ex_opclass)
    );

    typedef struct packed {
        logic [3:0]  cls;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        alt;
        logic        u1;
        logic        u2;
    } dec_t;

    // Reference decode: opcode -> (class, immediate format, register usage).
    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t r;
        logic [31:0] ii, si, bi, ji, ui;
        logic        has_rd;
        ii = {{20{w[31]}}, w[31:20]};
        si = {{20{w[31]}}, w[31:25], w[11:7]};
        bi = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        ji = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        ui = {w[31:12], 12'b0};
        r = '0;
        r.f3 = w[14:12];
        has_rd = 1'b1;
        case (w[6:0])
            7'b0110011: begin r.cls = 0; r.alt = w[30]; r.u1 = 1; r.u2 = 1; end
            7'b0010011: begin r.cls = 1; r.imm = ii; r.u1 = 1;
                              r.alt = (w[14:12] == 3'b101) & w[30]; end
            7'b0000011: begin r.cls = 2; r.imm = ii; r.u1 = 1; end
            7'b0100011: begin r.cls = 3; r.imm = si; r.u1 = 1; r.u2 = 1; has_rd = 0; end
            7'b1100011: begin r.cls = 4; r.imm = bi; r.u1 = 1; r.u2 = 1; has_rd = 0; end
            7'b1101111: begin r.cls = 5; r.imm = ji; end
            7'b1100111: begin r.cls = 6; r.imm = ii; r.u1 = 1; end
            7'b0110111: begin r.cls = 7; r.imm = ui; end
            7'b0010111: begin r.cls = 8; r.imm = ui; end
            7'b1110011, 7'b0001111: begin r.cls = 9; has_rd = 0; end
            default:    begin r.cls = 15; has_rd = 0; end
        endcase
        r.rd = has_rd ? w[11:7] : 5'd0;
        return r;
    endfunction

    task automatic idle_inputs();
        fetch_valid = 1'b0; fetch_instr = 32'h0; fetch_pc = 32'h0;
        rs1_data = 32'h0; rs2_data = 32'h0; ex_ready = 1'b1; flush = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic put(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] d1, input logic [31:0] d2);
        fetch_valid = v; fetch_instr = ins; fetch_pc = pc; rs1_data = d1; rs2_data = d2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        put(1'b1, 32'hFFF0_8293, 32'h100, 32'd7, 32'd9);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (ex_valid !== 1'b0) begin n_bad++;
            $display("FAIL reset_valid got %0b want 0", ex_valid); end
        n_cmp++; if (ex_pc !== RST_PC) begin n_bad++;
            $display("FAIL reset_pc got %h want %h", ex_pc, RST_PC); end
        n_cmp++; if ({ex_imm, ex_rd_address, ex_opclass, ex_rs1_data} !== '0) begin n_bad++;
            $display("FAIL reset_fields got %h/%0d/%0d/%h want 0", ex_imm, ex_rd_address,
                     ex_opclass, ex_rs1_data); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if ({fetch_ready, rs1_address, rs2_address} !== {1'b1, 5'd1, 5'd31}) begin
            n_bad++; $display("FAIL reset_release_comb got %b/%0d/%0d want 1/1/31",
                              fetch_ready, rs1_address, rs2_address); end
        @(posedge clk); #1;
        n_cmp++; if (ex_valid !== 1'b1 || ex_pc !== 32'h100) begin n_bad++;
            $display("FAIL reset_first_word got %0b/%h want 1/00000100", ex_valid, ex_pc); end
    endtask

    task automatic test_addi();
        do_reset();
        put(1'b1, 32'hFFF0_8293, 32'h100, 32'd7, 32'd3);
        @(posedge clk); #1;
        n_cmp++; if ({ex_valid, ex_opclass, ex_imm, ex_rd_address, ex_rs1_data, ex_pc} !==
                     {1'b1, 4'd1, 32'hFFFF_FFFF, 5'd5, 32'd7, 32'h100}) begin n_bad++;
            $display("FAIL addi got v=%0b cls=%0d imm=%h rd=%0d d1=%h pc=%h want 1/1/ffffffff/5/7/100",
                     ex_valid, ex_opclass, ex_imm, ex_rd_address, ex_rs1_data, ex_pc); end
        n_cmp++; if (ex_funct3 !== 3'd0 || ex_alt !== 1'b0) begin n_bad++;
            $display("FAIL addi_f3_alt got %0d/%0b want 0/0", ex_funct3, ex_alt); end
    endtask

    task automatic test_immediates();
        do_reset();
        put(1'b1, 32'hFE00_0EE3, 32'h200, 32'h0, 32'h0);
        @(posedge clk); #1;
        n_cmp++; if ({ex_imm, ex_rd_address, ex_opclass} !== {32'hFFFF_FFFC, 5'd0, 4'd4}) begin
            n_bad++; $display("FAIL beq_imm got %h/%0d/%0d want fffffffc/0/4",
                              ex_imm, ex_rd_address, ex_opclass); end
        @(negedge clk);
        put(1'b1, 32'h1234_51B7, 32'h204, 32'h0, 32'h0);
        @(posedge clk); #1;
        n_cmp++; if ({ex_imm, ex_rd_address, ex_opclass} !== {32'h1234_5000, 5'd3, 4'd7}) begin
            n_bad++; $display("FAIL lui_imm got %h/%0d/%0d want 12345000/3/7",
                              ex_imm, ex_rd_address, ex_opclass); end
        @(negedge clk);
        // srai x1,x2,3 keeps instr[30] as alt
        put(1'b1, 32'h4031_5093, 32'h208, 32'h0, 32'h0);
        @(posedge clk); #1;
        n_cmp++; if ({ex_alt, ex_funct3, ex_opclass} !== {1'b1, 3'd5, 4'd1}) begin n_bad++;
            $display("FAIL srai_alt got %0b/%0d/%0d want 1/5/1", ex_alt, ex_funct3, ex_opclass); end
    endtask

    task automatic test_load_use();
        do_reset();
        put(1'b1, 32'h0001_2303, 32'h300, 32'h0, 32'h0);
        @(posedge clk); #1;
        n_cmp++; if ({ex_valid, ex_opclass, ex_rd_address} !== {1'b1, 4'd2, 5'd6}) begin
            n_bad++; $display("FAIL lw_issue got %0b/%0d/%0d want 1/2/6",
                              ex_valid, ex_opclass, ex_rd_address); end
        @(negedge clk);
        put(1'b1, 32'h0013_03B3, 32'h304, 32'h11, 32'h22);
        #1;
        n_cmp++; if (fetch_ready !== 1'b0) begin n_bad++;
            $display("FAIL lu_stall_ready got %0b want 0", fetch_ready); end
        @(posedge clk); #1;
        n_cmp++; if (ex_valid !== 1'b0) begin n_bad++;
            $display("FAIL lu_bubble got %0b want 0", ex_valid); end
        @(negedge clk); #1;
        n_cmp++; if (fetch_ready !== 1'b1) begin n_bad++;
            $display("FAIL lu_resume_ready got %0b want 1", fetch_ready); end
        @(posedge clk); #1;
        n_cmp++; if ({ex_valid, ex_pc, ex_rd_address, ex_opclass} !=={1'b1, 32'h304, 5'd7, 4'd0})
        begin n_bad++; $display("FAIL lu_add_issue got %0b/%h/%0d/%0d want 1/304/7/0",
                                ex_valid, ex_pc, ex_rd_address, ex_opclass); end
        // Same load followed by a consumer of x0/x1 only: no stall.
        @(negedge clk);
        put(1'b1, 32'h0001_2303, 32'h310, 32'h0, 32'h0);
        @(negedge clk);
        put(1'b1, 32'h0010_03B3, 32'h314, 32'h0, 32'h0);
        #1;
        n_cmp++; if (fetch_ready !== 1'b1) begin n_bad++;
            $display("FAIL nohz_ready got %0b want 1", fetch_ready); end
        @(posedge clk); #1;
        n_cmp++; if (ex_valid !== 1'b1 || ex_pc !== 32'h314) begin n_bad++;
            $display("FAIL nohz_issue got %0b/%h want 1/314", ex_valid, ex_pc); end
        // Reset asserted in the middle of a stall cycle returns to reset state at once.
        @(negedge clk);
        put(1'b1, 32'h0001_2303, 32'h320, 32'h0, 32'h0);
        @(negedge clk);
        put(1'b1, 32'h0013_03B3, 32'h324, 32'h0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (ex_valid !== 1'b0 || ex_pc !== RST_PC || ex_rd_address !== 5'd0) begin
            n_bad++; $display("FAIL midstall_reset got %0b/%h/%0d want 0/%h/0",
                              ex_valid, ex_pc, ex_rd_address, RST_PC); end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
    endtask

    task automatic test_backpressure();
        logic [31:0] held_pc;
        do_reset();
        put(1'b1, 32'hFFF0_8293, 32'h400, 32'h5, 32'h6);
        @(posedge clk); #1;
        held_pc = 32'h400;
        @(negedge clk);
        ex_ready = 1'b0;
        put(1'b1, 32'h1234_51B7, 32'h404, 32'h0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (fetch_ready !== 1'b0) begin n_bad++;
                $display("FAIL bp_ready c%0d got %0b want 0", c, fetch_ready); end
            @(posedge clk); #1;
            n_cmp++; if ({ex_valid, ex_pc, ex_opclass, ex_rs1_data} !==
                         {1'b1, held_pc, 4'd1, 32'h5}) begin n_bad++;
                $display("FAIL bp_hold c%0d got %0b/%h/%0d want 1/%h/1",
                         c, ex_valid, ex_pc, ex_opclass, held_pc); end
            @(negedge clk);
        end
        ex_ready = 1'b1;
        #1;
        n_cmp++; if (fetch_ready !== 1'b1) begin n_bad++;
            $display("FAIL bp_resume_ready got %0b want 1", fetch_ready); end
        @(posedge clk); #1;
        n_cmp++; if (ex_valid !== 1'b1 || ex_pc !== 32'h404 || ex_opclass !== 4'd7) begin
            n_bad++; $display("FAIL bp_next got %0b/%h/%0d want 1/404/7",
                              ex_valid, ex_pc, ex_opclass); end
        @(negedge clk);
        fetch_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (ex_valid !== 1'b0) begin n_bad++;
            $display("FAIL bp_no_dup got %0b want 0", ex_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        put(1'b1, 32'hFFF0_8293, 32'h500, 32'h0, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        put(1'b1, 32'h1234_51B7, 32'h504, 32'h0, 32'h0);
        flush = 1'b1;
        #1;
        n_cmp++; if (fetch_ready !== 1'b0) begin n_bad++;
            $display("FAIL flush_ready got %0b want 0", fetch_ready); end
        @(posedge clk); #1;
        n_cmp++; if (ex_valid !== 1'b0) begin n_bad++;
            $display("FAIL flush_kill got %0b want 0", ex_valid); end
        @(negedge clk);
        flush = 1'b0;
        put(1'b1, 32'h0000_0000, 32'h600, 32'h0, 32'h0);
        @(posedge clk); #1;
        n_cmp++; if ({ex_valid, ex_opclass, ex_rd_address, ex_imm, ex_pc} !==
                     {1'b1, 4'd15, 5'd0, 32'h0, 32'h600}) begin n_bad++;
            $display("FAIL illegal got %0b/%0d/%0d/%h/%h want 1/15/0/0/600",
                     ex_valid, ex_opclass, ex_rd_address, ex_imm, ex_pc); end
    endtask

    task automatic test_random();
        logic [6:0] ops [13];
        logic [31:0] w;
        dec_t  d, m;
        logic  m_valid, e_hz, e_adv, e_fr;
        logic [31:0] m_pc, m_d1, m_d2;
        int    stalls;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
                7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011, 7'b0001111, 7'b0101011,
                7'b0000010};
        do_reset();
        m_valid = 1'b0; m = '0; m_pc = RST_PC; m_d1 = '0; m_d2 = '0;
        stalls = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            w = $urandom;
            w[6:0]   = ops[$urandom_range(0, 12)];
            w[11:7]  = 5'($urandom_range(0, 3));
            w[19:15] = 5'($urandom_range(0, 3));
            w[24:20] = 5'($urandom_range(0, 3));
            put($urandom_range(0, 3) != 0, w, $urandom, $urandom, $urandom);
            ex_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 15) == 0;
            #1;
            d = ref_decode(w);
            e_hz = m_valid && m.cls == 4'd2 && m.rd != 5'd0 && fetch_valid &&
                   ((d.u1 && w[19:15] == m.rd) || (d.u2 && w[24:20] == m.rd));
            e_adv = !m_valid || ex_ready;
            e_fr = e_adv && !e_hz && !flush;
            if (e_hz && e_adv && !flush) stalls++;
            n_cmp++; if ({fetch_ready, rs1_address, rs2_address} !== {e_fr, w[19:15], w[24:20]})
            begin n_bad++; $display("FAIL rnd_comb i%0d got %b/%0d/%0d want %b/%0d/%0d", i,
                fetch_ready, rs1_address, rs2_address, e_fr, w[19:15], w[24:20]); end
            if (flush) m_valid = 1'b0;
            else if (e_adv) begin
                if (e_hz || !fetch_valid) m_valid = 1'b0;
                else begin
                    m_valid = 1'b1; m = d; m_pc = fetch_pc; m_d1 = rs1_data; m_d2 = rs2_data;
                end
            end
            @(posedge clk); #1;
            n_cmp++; if (ex_valid !== m_valid) begin n_bad++;
                $display("FAIL rnd_valid i%0d got %0b want %0b", i, ex_valid, m_valid); end
            if (m_valid) begin
                n_cmp++;
                if ({ex_pc, ex_rs1_data, ex_rs2_data, ex_rd_address, ex_funct3, ex_alt,
                     ex_opclass} !== {m_pc, m_d1, m_d2, m.rd, m.f3, m.alt, m.cls} ||
                    (m.cls != 4'd9 && ex_imm !== m.imm)) begin
                    n_bad++;
                    $display("FAIL rnd_fields i%0d got pc=%h imm=%h rd=%0d f3=%0d alt=%0b cls=%0d want pc=%h imm=%h rd=%0d f3=%0d alt=%0b cls=%0d",
                             i, ex_pc, ex_imm, ex_rd_address, ex_funct3, ex_alt, ex_opclass,
                             m_pc, m.imm, m.rd, m.f3, m.alt, m.cls);
                end
            end
        end
        $display("random run: %0d load-use stall cycles exercised", stalls);
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_immediates();
        test_load_use();
        test_backpressure();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I decode stage between fetch and execute.
- Drives the register-file read addresses combinationally from the incoming instruction, then captures the returned operand data into an execute-facing pipeline register.
- Extracts the immediate, destination register and an operation class.
- Detects load-use hazards and stalls; honours flush on taken branches and jumps.
- Execute forwards from memory and writeback, so only load-use needs a stall.

Parameters:
- RESET_PC, 32'h0000_0000, value of ex_pc under reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_valid  in  1  fetch presents an instruction.
- fetch_instr  in  32  instruction word.
- fetch_pc  in  32  instruction address.
- fetch_ready  out  1  decode accepts the fetch word this cycle.
- rs1_address  out  5  to regfile, combinational from fetch_instr[19:15].
- rs2_address  out  5  to regfile, combinational from fetch_instr[24:20].
- rs1_data  in  32  from regfile, same cycle.
- rs2_data  in  32  from regfile, same cycle.
- ex_ready  in  1  execute consumes the ex_* register this cycle.
- flush  in  1  taken branch/jump; kill all younger instructions.
- ex_valid  out  1  ex_* register holds a live instruction.
- ex_pc  out  32  registered pc.
- ex_rs1_data  out  32  registered operand 1.
- ex_rs2_data  out  32  registered operand 2.
- ex_imm  out  32  sign-extended immediate.
- ex_rd_address  out  5  destination register; 0 if none.
- ex_funct3  out  3  instr[14:12].
- ex_alt  out  1  instr[30] for R-type SUB/SRA, and for I-type SRAI only.
- ex_opclass  out  4  operation class:
  - 0 OP, 1 OP-IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 SYSTEM/FENCE (nop), 15 ILLEGAL.

Behaviour:
- Reset (async, rst_n=0): ex_valid=0, ex_pc=RESET_PC, all other ex_* = 0. fetch_ready is combinational and not affected by reset.
- Opcode decode, on instr[6:0]:
  - 0110011 OP (R), 0010011 OP-IMM (I), 0000011 LOAD (I), 0100011 STORE (S), 1100011 BRANCH (B), 1101111 JAL (J), 1100111 JALR (I), 0110111 LUI (U), 0010111 AUIPC (U), 1110011/0001111 class 9.
  - Anything else, or instr[1:0]!=2'b11, gives class 15.
- Immediates: I/S/B/J are sign-extended from instr[31]; U = {instr[31:12],12'b0}; B and J have bit0 = 0. R-type and class 15 give imm 0.
- rd_address: forced 0 for STORE, BRANCH, class 9 and class 15.
- Register usage:
  - uses_rs1 for OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - uses_rs2 for OP, STORE, BRANCH.
  - Unused addresses are still driven from the instruction; their data is captured but has no meaning.
- Load-use hazard (hz), all of these must hold:
  - ex_valid=1 and ex_opclass=LOAD and ex_rd_address!=0;
  - (uses_rs1 and rs1 == ex_rd_address) or (uses_rs2 and rs2 == ex_rd_address);
  - fetch_valid=1.
- advance = !ex_valid | ex_ready.
- fetch_ready = advance & !hz & !flush (combinational).
- Register update, first matching rule wins:
  1. flush=1: ex_valid<=0, fetch word dropped (fetch_ready=0).
  2. advance & hz: insert bubble, ex_valid<=0; fetch word held.
  3. advance & fetch_valid: capture all fields from fetch_instr and rs*_data; ex_valid<=1.
  4. advance & !fetch_valid: ex_valid<=0.
  5. !advance: hold all ex_* unchanged.
- Latency: 1 cycle from fetch acceptance to ex_valid.
- Throughput: 1 instruction/cycle with no hazards.
- A load-use stall lasts exactly 1 cycle, because the load leaves ex_* on the bubble cycle.
- Class 15 passes down with ex_valid=1; execute raises the trap.
- Reset mid-stall or mid-flush: immediate return to the reset values above; no instruction is retained.

Test Plan:
- Reset: hold rst_n=0 with fetch_valid=1 -> ex_valid=0, ex_pc=RESET_PC; after release, first word appears 1 cycle after acceptance.
- addi x5,x1,-1 (0xFFF08293), pc=0x100, rs1_data=7, ex_ready=1 -> next cycle ex_valid=1, ex_opclass=1, ex_imm=0xFFFFFFFF, ex_rd_address=5, ex_rs1_data=7, ex_pc=0x100.
- Immediates: beq with offset -4 (0xFE000EE3) -> ex_imm=0xFFFFFFFC, rd=0, class 4; lui x3,0x12345 -> ex_imm=0x12345000.
- Load-use: lw x6,0(x2) followed by add x7,x6,x1 -> fetch_ready=0 one cycle, one bubble (ex_valid=0), then add issued; same sequence with add x7,x0,x1 -> no stall.
- Backpressure: ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* stable, fetch_ready=0; resumes with no drop or duplicate.
- Flush: flush=1 with fetch_valid=1 and ex_valid=1 -> next cycle ex_valid=0, fetch_ready=0 that cycle; illegal word 0x00000000 -> ex_opclass=15, ex_valid=1.
